// File: rtl/btn_pkg.sv
// Shared types and default timing constants for board push-button conditioning.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } btn_state_e;

  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEBOUNCE_20MS       = CLK_HZ / 50;
  localparam int unsigned REPEAT_DELAY_500MS  = CLK_HZ / 2;
  localparam int unsigned REPEAT_PERIOD_200MS = CLK_HZ / 5;

  // Counter width able to hold any value up to n, with one spare bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return int'($clog2(n)) + 1;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_step_conditioner_sync_debounce.sv
// Two-FF synchroniser, stability-count debouncer and press/release edge pulses.
module sync_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS
) (
  input  logic clk_in,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_c,
  output logic release_c
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic             s1;
  logic             s0;
  logic [CNT_W-1:0] db_cnt;
  logic             accept_c;

  // A level change is accepted once the synchronised input has disagreed long enough.
  assign accept_c  = (s0 != level) && (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign press_c   = accept_c && !level;
  assign release_c = accept_c && level;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1 <= 1'b0;
      s0 <= 1'b0;
    end else begin
      s1 <= raw;
      s0 <= s1;
    end
  end

  // Count consecutive disagreeing cycles; toggle the level and pulse on acceptance.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      db_cnt        <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= press_c;
      release_pulse <= release_c;
      if (s0 == level) begin
        db_cnt <= '0;
      end else if (accept_c) begin
        db_cnt <= '0;
        level  <= ~level;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_step_conditioner.sv
// Frequency-select button conditioner: debounced level, edge pulses and auto-repeat steps.
module button_step_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEBOUNCE_20MS,
  parameter bit          REPEAT_EN            = 1'b1,
  parameter int unsigned REPEAT_DELAY_CYCLES  = REPEAT_DELAY_500MS,
  parameter int unsigned REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_200MS
) (
  input  logic clk_in,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse,
  output logic repeat_active
);

  localparam int unsigned RP_MAX = max2(max2(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES),
                                        DEBOUNCE_CYCLES);
  localparam int unsigned RP_W   = cnt_width(RP_MAX);

  logic            press_c;
  logic            release_c;
  btn_state_e      state;
  btn_state_e      state_next;
  logic [RP_W-1:0] rp_cnt;
  logic [RP_W-1:0] rp_cnt_next;
  logic            repeat_c;

  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk_in        (clk_in),
    .rst           (rst),
    .raw           (btn_raw),
    .level         (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_c       (press_c),
    .release_c     (release_c)
  );

  // Repeat FSM next state; a release always wins and suppresses any repeat pulse.
  always_comb begin
    state_next  = state;
    rp_cnt_next = rp_cnt;
    repeat_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_c) begin
          state_next  = HELD_DELAY;
          rp_cnt_next = '0;
        end
      end
      HELD_DELAY: begin
        if (!REPEAT_EN) begin
          rp_cnt_next = '0;
        end else if (rp_cnt == RP_W'(REPEAT_DELAY_CYCLES - 1)) begin
          repeat_c    = 1'b1;
          rp_cnt_next = '0;
          state_next  = HELD_REPEAT;
        end else begin
          rp_cnt_next = rp_cnt + RP_W'(1);
        end
      end
      HELD_REPEAT: begin
        if (rp_cnt == RP_W'(REPEAT_PERIOD_CYCLES - 1)) begin
          repeat_c    = 1'b1;
          rp_cnt_next = '0;
        end else begin
          rp_cnt_next = rp_cnt + RP_W'(1);
        end
      end
      default: begin
        state_next  = IDLE;
        rp_cnt_next = '0;
      end
    endcase
    if (release_c) begin
      state_next  = IDLE;
      rp_cnt_next = '0;
      repeat_c    = 1'b0;
    end
  end

  // State, repeat counter and registered step/repeat outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state         <= IDLE;
      rp_cnt        <= '0;
      step_pulse    <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      state         <= state_next;
      rp_cnt        <= rp_cnt_next;
      step_pulse    <= press_c | repeat_c;
      repeat_active <= (state_next == HELD_REPEAT);
    end
  end

endmodule
